reg_access_seq: RTL and testbench
=================================

REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 8, register/operand data width
  ADDR_W, 2, register address width (4 registers)
  OPC_W, 4, opcode width passed through to the execute unit
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  req_valid  in  1  instruction request valid
  req_ready  out  1  sequencer can accept a request
  req_rx  in  ADDR_W  destination / operand A register
  req_ry  in  ADDR_W  operand B register
  req_opcode  in  OPC_W  operation code
  req_wb  in  1  1 = write result to Rx; 0 = discard (compare-type op)
  rf_rd_addr_a  out  ADDR_W  register file read address A
  rf_rd_addr_b  out  ADDR_W  register file read address B
  rf_rd_data_a  in  DATA_W  register file read data A (combinational from address)
  rf_rd_data_b  in  DATA_W  register file read data B
  rf_we  out  1  register file write enable
  rf_wr_addr  out  ADDR_W  register file write address
  rf_wr_data  out  DATA_W  register file write data
  exe_valid  out  1  operands presented to execute unit
  exe_opcode, exe_opa, exe_opb  out  OPC_W/DATA_W/DATA_W  latched opcode and operands
  exe_done  in  1  execute result valid this cycle
  exe_result  in  DATA_W  execute result
  done  out  1  one-cycle pulse: instruction retired
  zero_flag  out  1  result-was-zero flag (present only with REG_ACCESS_SEQ_ZFLAG_EN)
REQ-003 The single clock SHALL be clk; reset SHALL be rst, synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, READ, EXEC, WB; encoding from the shared package.
REQ-005 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready; on accept latch rx, ry, opcode, wb and go to READ.
REQ-006 In READ, rf_rd_addr_a/b SHALL equal latched rx/ry; rf_rd_data_a/b SHALL be captured into exe_opa/exe_opb at the end of READ; next state EXEC.
REQ-007 In EXEC, exe_valid SHALL be 1 with stable exe_opcode/opa/opb; on exe_done=1 capture exe_result and go to WB; otherwise remain in EXEC indefinitely.
REQ-008 exe_done outside EXEC SHALL be ignored (no state or data change).
REQ-009 In WB, for exactly one cycle: rf_we = latched wb, rf_wr_addr = rx, rf_wr_data = captured result, done = 1; next state IDLE.
REQ-010 rf_we SHALL never assert outside WB; at most one write per accepted request.
REQ-011 Minimum latency SHALL be: accept cycle N, READ N+1, EXEC N+2, WB N+3 (exe_done in first EXEC cycle); back-to-back accept no earlier than N+4.
REQ-012 A request whose rx equals the previous request's rx SHALL read the written-back value (READ follows WB by at least 2 cycles).
REQ-013 Data widths SHALL match exactly; no truncation or extension of operands or result.

Reset
REQ-014 On rst=1 at a clock edge: state IDLE, req_ready 1 after release, rf_we 0, done 0, exe_valid 0, all address/data outputs and latches 0, zero_flag 0.
REQ-015 Reset in any state SHALL abandon the instruction with no register-file write.

Configuration
REQ-016 With REG_ACCESS_SEQ_ZFLAG_EN defined: zero_flag port exists, updated in WB to (result == 0) regardless of wb, held otherwise; without it the port and logic are absent and all other behaviour is identical.

Structure
REQ-017 Package reg_access_pkg SHALL hold the state enum and DATA_W/ADDR_W/OPC_W defaults shared with the register file and execute unit.
REQ-018 The block SHALL be one module with no sub-module; the FSM and operand/result latches live together.

Verification
REQ-019 Reset: assert rst mid-EXEC -> next cycle IDLE, req_ready=1 after release, no rf_we, outputs 0.
REQ-020 Basic op: rx=1, ry=2, wb=1, regs r1=0x05 r2=0x03, exe returns 0x08 same cycle -> exe_opa=0x05, exe_opb=0x03, rf_we at N+3 with addr 1, data 0x08, done pulse.
REQ-021 Stall: exe_done delayed 5 cycles -> exe_valid and operands stable all 5 cycles, req_ready=0, single write after.
REQ-022 No writeback: wb=0, result 0x00 -> rf_we stays 0, done pulses, zero_flag=1 when ZFLAG_EN defined.
REQ-023 Dependency: op1 writes r0=0xAA, op2 reads rx=0 -> op2 exe_opa=0xAA; spurious exe_done in IDLE ignored.

Source files
------------

// File: rtl/reg_access_pkg.sv
// reg_access_pkg: shared sequencer state encoding and default widths for the
// register file, the execute unit and the sequencer.
package reg_access_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_OPC_W  = 4;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;
endpackage

// File: rtl/reg_access_seq.sv
// reg_access_seq: read-execute-writeback instruction sequencer for a small register file.
// Define REG_ACCESS_SEQ_ZFLAG_EN to add the zero_flag output.
module reg_access_seq #(
    parameter int DATA_W = reg_access_pkg::DEF_DATA_W,
    parameter int ADDR_W = reg_access_pkg::DEF_ADDR_W,
    parameter int OPC_W  = reg_access_pkg::DEF_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rx,
    input  logic [ADDR_W-1:0] req_ry,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic              req_wb,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              exe_valid,
    output logic [OPC_W-1:0]  exe_opcode,
    output logic [DATA_W-1:0] exe_opa,
    output logic [DATA_W-1:0] exe_opb,
    input  logic              exe_done,
    input  logic [DATA_W-1:0] exe_result,
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
    output logic              zero_flag,
`endif
    output logic              done
);
    import reg_access_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [OPC_W-1:0]  opc_q, opc_d;
    logic              wb_q, wb_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
    logic              zf_q, zf_d;
`endif

    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        opc_d   = opc_q;
        wb_d    = wb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
        zf_d    = zf_q;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = READ;
                rx_d    = req_rx;
                ry_d    = req_ry;
                opc_d   = req_opcode;
                wb_d    = req_wb;
            end
            READ: begin
                state_d = EXEC;
                opa_d   = rf_rd_data_a;
                opb_d   = rf_rd_data_b;
            end
            EXEC: if (exe_done) begin
                state_d = WB;
                res_d   = exe_result;
            end
            WB: begin
                state_d = IDLE;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
                zf_d    = (res_q == '0);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            opc_q   <= '0;
            wb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
            zf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            opc_q   <= opc_d;
            wb_q    <= wb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
            zf_q    <= zf_d;
`endif
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign exe_valid    = (state_q == EXEC);
    assign done         = (state_q == WB);
    assign rf_we        = (state_q == WB) && wb_q;
    assign rf_rd_addr_a = rx_q;
    assign rf_rd_addr_b = ry_q;
    assign rf_wr_addr   = rx_q;
    assign rf_wr_data   = res_q;
    assign exe_opcode   = opc_q;
    assign exe_opa      = opa_q;
    assign exe_opb      = opb_q;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
    // Valid during the writeback cycle itself, then held until the next one.
    assign zero_flag    = (state_q == WB) ? (res_q == '0) : zf_q;
`endif
endmodule

// File: tb/tb_reg_access_seq.sv
// tb_reg_access_seq: directed bench for reg_access_seq with a register-file model
// and a scoreboard of expected writebacks.
module tb_reg_access_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_rx = '0, req_ry = '0;
    logic [3:0] req_opcode = '0;
    logic       req_wb = 1'b0;
    logic [1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
    logic [7:0] rf_rd_data_a, rf_rd_data_b, rf_wr_data;
    logic       rf_we, exe_valid, done;
    logic [3:0] exe_opcode;
    logic [7:0] exe_opa, exe_opb;
    logic       exe_done = 1'b0;
    logic [7:0] exe_result = '0;
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
    logic       zero_flag;
`endif

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       zf;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] regs [4];
    logic [7:0] exp_regs [4];
    logic       pl_en = 1'b0;
    logic [1:0] pl_addr = '0;
    logic [7:0] pl_data = '0;
    int         wr_count = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    reg_access_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rx(req_rx), .req_ry(req_ry), .req_opcode(req_opcode), .req_wb(req_wb),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .exe_valid(exe_valid), .exe_opcode(exe_opcode), .exe_opa(exe_opa), .exe_opb(exe_opb),
        .exe_done(exe_done), .exe_result(exe_result),
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
        .zero_flag(zero_flag),
`endif
        .done(done)
    );

    assign rf_rd_data_a = regs[rf_rd_addr_a];
    assign rf_rd_data_b = regs[rf_rd_addr_b];

    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (rf_we) begin
            regs[rf_wr_addr] <= rf_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] rx, input logic [1:0] ry, input logic [3:0] opc,
                          input logic wb, input logic [7:0] res, input int stall);
        logic [7:0] ea, eb;
        exp_t       e;
        int         w0;
        ea = exp_regs[rx];
        eb = exp_regs[ry];
        w0 = wr_count;
        e.we = wb; e.addr = rx; e.data = res; e.zf = (res == 8'h00);
        sb.push_back(e);
        req_rx = rx; req_ry = ry; req_opcode = opc; req_wb = wb; req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        chk("read_ready", req_ready, 0);
        chk("rd_addr_a", rf_rd_addr_a, rx);
        chk("rd_addr_b", rf_rd_addr_b, ry);
        step;
        chk("exe_valid", exe_valid, 1);
        chk("exe_opa", exe_opa, ea);
        chk("exe_opb", exe_opb, eb);
        chk("exe_opcode", exe_opcode, opc);
        for (int i = 0; i < stall; i++) begin
            step;
            chk("stall_valid", exe_valid, 1);
            chk("stall_opa", exe_opa, ea);
            chk("stall_opb", exe_opb, eb);
            chk("stall_ready", req_ready, 0);
            chk("stall_we", rf_we, 0);
        end
        exe_done = 1'b1; exe_result = res;
        step;
        exe_done = 1'b0; exe_result = 8'hFF;
        e = sb.pop_front();
        chk("wb_done", done, 1);
        chk("wb_we", rf_we, e.we);
        chk("wb_addr", rf_wr_addr, e.addr);
        chk("wb_data", rf_wr_data, e.data);
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
        chk("wb_zf", zero_flag, e.zf);
`endif
        if (wb) exp_regs[rx] = res;
        step;
        chk("post_done", done, 0);
        chk("post_ready", req_ready, 1);
        chk("post_we", rf_we, 0);
        chk("write_count", wr_count, w0 + (wb ? 1 : 0));
    endtask

    initial begin
        logic [7:0] init [4];
        int w0;
        init[0] = 8'h11; init[1] = 8'h05; init[2] = 8'h03; init[3] = 8'h00;
        rst = 1'b1;
        pl_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pl_addr = 2'(i); pl_data = init[i]; exp_regs[i] = init[i];
            step;
        end
        pl_en = 1'b0;
        rst = 1'b0;
        step;
        chk("rst_ready", req_ready, 1);
        chk("rst_we", rf_we, 0);
        chk("rst_done", done, 0);
        chk("rst_exe_valid", exe_valid, 0);
        chk("rst_opa", exe_opa, 0);
        chk("rst_wr_data", rf_wr_data, 0);
`ifdef REG_ACCESS_SEQ_ZFLAG_EN
        chk("rst_zf", zero_flag, 0);
`endif
        run_op(2'd1, 2'd2, 4'd3, 1'b1, 8'h08, 0);
        run_op(2'd3, 2'd1, 4'd2, 1'b1, 8'h5A, 5);
        run_op(2'd2, 2'd2, 4'd7, 1'b0, 8'h00, 0);
        run_op(2'd0, 2'd1, 4'd1, 1'b1, 8'hAA, 0);
        exe_done = 1'b1; exe_result = 8'h33;
        for (int i = 0; i < 2; i++) begin
            step;
            chk("spur_ready", req_ready, 1);
            chk("spur_valid", exe_valid, 0);
            chk("spur_we", rf_we, 0);
            chk("spur_done", done, 0);
            chk("spur_data", rf_wr_data, 8'hAA);
        end
        exe_done = 1'b0;
        run_op(2'd0, 2'd3, 4'd4, 1'b1, 8'h01, 1);
        w0 = wr_count;
        req_rx = 2'd2; req_ry = 2'd1; req_opcode = 4'd9; req_wb = 1'b1; req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        step;
        chk("pre_rst_valid", exe_valid, 1);
        rst = 1'b1; exe_done = 1'b1; exe_result = 8'h77;
        step;
        exe_done = 1'b0;
        chk("midrst_ready", req_ready, 1);
        chk("midrst_valid", exe_valid, 0);
        chk("midrst_we", rf_we, 0);
        chk("midrst_done", done, 0);
        chk("midrst_opa", exe_opa, 0);
        chk("midrst_opb", exe_opb, 0);
        chk("midrst_wr_data", rf_wr_data, 0);
        chk("midrst_rd_addr", rf_rd_addr_a, 0);
        rst = 1'b0;
        step;
        chk("rel_ready", req_ready, 1);
        chk("rel_we", rf_we, 0);
        chk("rel_writes", wr_count, w0);
        for (int i = 0; i < 4; i++) chk("final_reg", regs[i], exp_regs[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
